// File: rtl/b10_cone_sweep_ctrl_if.sv
// Result stream of the b10 cone sweep controller.
// One beat per swept vector: the vector plus the reference and optimised cone outputs.
interface b10_cone_sweep_ctrl_if #(
    parameter int NIN = 15
) ();
    logic           res_valid;
    logic           res_ready;
    logic [NIN-1:0] res_vec;
    logic           res_ref;
    logic           res_opt;

    // The controller produces beats
    modport master (
        output res_valid,
        output res_vec,
        output res_ref,
        output res_opt,
        input  res_ready
    );

    // The sink consumes beats
    modport slave (
        input  res_valid,
        input  res_vec,
        input  res_ref,
        input  res_opt,
        output res_ready
    );
endinterface

// File: rtl/b10_cone_sweep_ctrl.sv
// On-chip equivalence harness for the b10 projected output cone.
// Walks an inclusive ascending range of input vectors. Each vector is held on
// cone_x_o for SETTLE cycles. The reference and optimised cone outputs are then
// captured and streamed out as one beat. Ones and mismatches are counted with
// saturation. The sweep can optionally stop on the first mismatch.
module b10_cone_sweep_ctrl #(
    parameter int NIN    = 15,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    // sweep control
    input  logic                 start_i,
    input  logic [NIN-1:0]       first_vec_i,
    input  logic [NIN-1:0]       last_vec_i,
    input  logic                 stop_on_mm_i,
    // cone under test
    output logic [NIN-1:0]       cone_x_o,
    input  logic                 cone_y_ref_i,
    input  logic                 cone_y_opt_i,
    // result stream
    b10_cone_sweep_ctrl_if.master res_if,
    // status
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     ones_cnt_o,
    output logic [CNT_W-1:0]     mismatch_cnt_o,
    output logic                 mm_found_o,
    output logic [NIN-1:0]       first_mm_vec_o
);

    // Settle counter runs 0..SETTLE-1; keep at least one bit so SETTLE=1 still elaborates
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [NIN-1:0]   cone_x_q;
    logic [NIN-1:0]   last_q;
    logic             stop_q;
    logic [SC_W-1:0]  settle_cnt_q;
    logic             res_valid_q;
    logic [NIN-1:0]   res_vec_q;
    logic             res_ref_q;
    logic             res_opt_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] mm_cnt_q;
    logic             mm_found_q;
    logic [NIN-1:0]   first_mm_q;

    // Next-value helpers shared by the FSM
    logic [CNT_W-1:0] ones_d;
    logic [CNT_W-1:0] mm_cnt_d;
    logic [NIN-1:0]   cone_x_inc_d;
    logic             cap_mm_d;
    logic             beat_mm_d;
    logic             settle_last_d;
    logic             at_last_d;
    logic             end_sweep_d;

    // Saturating counter increments, mismatch flags and sweep-end condition
    always_comb begin
        cap_mm_d      = cone_y_ref_i ^ cone_y_opt_i;
        beat_mm_d     = res_ref_q ^ res_opt_q;
        settle_last_d = (settle_cnt_q == SETTLE_LAST);
        at_last_d     = (cone_x_q == last_q);
        end_sweep_d   = at_last_d || (stop_q && beat_mm_d);
        cone_x_inc_d  = cone_x_q + NIN'(1);
        ones_d        = ones_q;
        mm_cnt_d      = mm_cnt_q;
        if (cone_y_opt_i && (ones_q != {CNT_W{1'b1}})) begin
            ones_d = ones_q + CNT_W'(1);
        end
        if (cap_mm_d && (mm_cnt_q != {CNT_W{1'b1}})) begin
            mm_cnt_d = mm_cnt_q + CNT_W'(1);
        end
    end

    // Sweep FSM with all outputs registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cone_x_q     <= '0;
            last_q       <= '0;
            stop_q       <= 1'b0;
            settle_cnt_q <= '0;
            res_valid_q  <= 1'b0;
            res_vec_q    <= '0;
            res_ref_q    <= 1'b0;
            res_opt_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ones_q       <= '0;
            mm_cnt_q     <= '0;
            mm_found_q   <= 1'b0;
            first_mm_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        last_q     <= last_vec_i;
                        stop_q     <= stop_on_mm_i;
                        ones_q     <= '0;
                        mm_cnt_q   <= '0;
                        mm_found_q <= 1'b0;
                        first_mm_q <= '0;
                        if (first_vec_i > last_vec_i) begin
                            // Empty range: finish without producing any beat
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cone_x_q     <= first_vec_i;
                            settle_cnt_q <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (settle_last_d) begin
                        // Cone has had SETTLE cycles to propagate: capture both versions
                        res_vec_q   <= cone_x_q;
                        res_ref_q   <= cone_y_ref_i;
                        res_opt_q   <= cone_y_opt_i;
                        res_valid_q <= 1'b1;
                        ones_q      <= ones_d;
                        mm_cnt_q    <= mm_cnt_d;
                        if (cap_mm_d && !mm_found_q) begin
                            mm_found_q <= 1'b1;
                            first_mm_q <= cone_x_q;
                        end
                        state_q <= ST_EMIT;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SC_W'(1);
                    end
                end

                ST_EMIT: begin
                    // Beat and cone_x stay frozen until the sink takes the beat
                    if (res_if.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (end_sweep_d) begin
                            // Stopping at last_q guarantees cone_x never wraps
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cone_x_q     <= cone_x_inc_d;
                            settle_cnt_q <= '0;
                            state_q      <= ST_SETTLE;
                        end
                    end
                end

                ST_DONE: begin
                    // done_q drops through the default above; results hold until next start
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cone_x_o         = cone_x_q;
    assign res_if.res_valid = res_valid_q;
    assign res_if.res_vec   = res_vec_q;
    assign res_if.res_ref   = res_ref_q;
    assign res_if.res_opt   = res_opt_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign ones_cnt_o       = ones_q;
    assign mismatch_cnt_o   = mm_cnt_q;
    assign mm_found_o       = mm_found_q;
    assign first_mm_vec_o   = first_mm_q;

endmodule
